adder_operand_loader: RTL and testbench

//  Upstream stage for the 4-bit ripple-carry adder: builds operands A and B from one 4-bit switch bus

---
 rtl/adder_loader_pkg.sv | 17 +
 rtl/adder_operand_loader_load_debouncer.sv | 52 +++++
 rtl/adder_operand_loader.sv | 146 ++++++++++++++
 tb/tb_adder_operand_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_loader_pkg.sv
// ----------------------------------------------------------------------------
// adder_loader_pkg
//   Shared definitions for the adder operand loader: FSM state encodings
//   (also driven out on the State LEDs) and the default operand width.
// ----------------------------------------------------------------------------
package adder_loader_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        CALC  = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/adder_operand_loader_load_debouncer.sv
// ----------------------------------------------------------------------------
// load_debouncer
//   Filters a synchronized push-button level. The output level follows the
//   input only after the input has differed from the current output for
//   DEB_CYCLES consecutive cycles; any return to the current level restarts
//   the count. Only built when LOAD_DEBOUNCE_EN is defined.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high (level resets to 0)
//   din_i    in   synchronized raw level
//   level_o  out  debounced level
// ----------------------------------------------------------------------------
`ifdef LOAD_DEBOUNCE_EN
module load_debouncer #(
    parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (din_i == level_q) begin
            cnt_d = 16'd0;                      // bounce back: restart
        end else if (cnt_q == DEB_CYCLES - 16'd1) begin
            level_d = din_i;                    // held long enough
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 16'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule
`endif

// File: rtl/adder_operand_loader.sv
// ----------------------------------------------------------------------------
// adder_operand_loader
//   Builds operands A and B for an external combinational adder from a single
//   switch bus, one Load press at a time, then latches the adder's
//   {Cout,Sum} into a stable Result register.
//   Optional feature: define LOAD_DEBOUNCE_EN to insert load_debouncer between
//   the synchronizer and the edge detector.
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   Din[WIDTH]        operand value from switches
//   Load              raw push-button (asynchronous)
//   Clr               synchronous clear, same effect as rst except synchronizer
//   Cin_sw            carry-in switch
//   A, B, Cin         registered operands to the adder
//   Sum_in, Cout_in   adder outputs
//   Result[WIDTH+1]   latched {Cout_in,Sum_in}
//   Result_valid      Result matches current A,B,Cin
//   State[2]          FSM state for LEDs
// ----------------------------------------------------------------------------
module adder_operand_loader
    import adder_loader_pkg::*;
#(
    parameter int          WIDTH      = DEFAULT_WIDTH,
    parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    input  logic             Clr,
    input  logic             Cin_sw,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    input  logic [WIDTH-1:0] Sum_in,
    input  logic             Cout_in,
    output logic [WIDTH:0]   Result,
    output logic             Result_valid,
    output logic [1:0]       State
);

    // ---------------- Load synchronizer + edge detector ----------------
    logic sync1_q, sync2_q, prev_q;
    logic load_lvl, load_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= Load;
            sync2_q <= sync1_q;
            prev_q  <= load_lvl;
        end
    end

`ifdef LOAD_DEBOUNCE_EN
    load_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sync2_q),
        .level_o (load_lvl)
    );
`else
    logic unused_deb;
    assign unused_deb = ^DEB_CYCLES;
    assign load_lvl   = sync2_q;
`endif

    // One cycle wide per press, however long Load is held.
    assign load_pulse = load_lvl & ~prev_q;

    // ---------------- Operand / result FSM ----------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             rv_q, rv_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        res_d   = res_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: begin
                if (load_pulse) begin
                    a_d     = Din;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (load_pulse) begin
                    b_d     = Din;
                    cin_d   = Cin_sw;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A/B/Cin have been stable for one cycle; adder has settled.
                res_d   = {Cout_in, Sum_in};
                rv_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Next press starts a new operation; old Result stays visible.
                if (load_pulse) begin
                    a_d     = Din;
                    rv_d    = 1'b0;
                    state_d = GOT_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clr drops any coincident load since it wins over the FSM update.
    always_ff @(posedge clk) begin
        if (rst || Clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign Cin          = cin_q;
    assign Result       = res_q;
    assign Result_valid = rv_q;
    assign State        = state_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
module tb_adder_operand_loader;
    import adder_loader_pkg::*;

`ifdef LOAD_DEBOUNCE_EN
    localparam logic [15:0] DEB = 16'd8;
    localparam int          LAT = 2 + 8;
`else
    localparam logic [15:0] DEB = 16'd1000;
    localparam int          LAT = 2;
`endif

    logic       clk, rst, Load, Clr, Cin_sw;
    logic [3:0] Din, A, B, Sum_in;
    logic       Cin, Cout_in, Result_valid;
    logic [4:0] Result;
    logic [1:0] State;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] exp_q[$];

    // 4-bit adder sitting downstream of the loader
    assign {Cout_in, Sum_in} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

    adder_operand_loader #(.WIDTH(4), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .Din(Din), .Load(Load), .Clr(Clr),
        .Cin_sw(Cin_sw), .A(A), .B(B), .Cin(Cin), .Sum_in(Sum_in),
        .Cout_in(Cout_in), .Result(Result), .Result_valid(Result_valid),
        .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d, input logic c);
        @(negedge clk);
        Din = d; Cin_sw = c; Load = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        Load = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic clear();
        @(negedge clk); Clr = 1'b1;
        @(negedge clk); Clr = 1'b0;
    endtask

    // Monitor: each rising Result_valid consumes one expected Result.
    initial begin
        logic       rv_prev;
        logic [4:0] e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (Result_valid && !rv_prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got %0h expected none", Result);
                end else begin
                    e = exp_q.pop_front();
                    if (Result !== e) begin
                        n_err++;
                        $display("FAIL result: got %0h expected %0h", Result, e);
                    end
                end
            end
            rv_prev = Result_valid;
        end
    end

    initial begin
        rst = 1'b1; Load = 1'b0; Clr = 1'b0; Cin_sw = 1'b0; Din = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {A, B, Cin, Result, Result_valid}, 32'h0);
        check("reset_state", State, IDLE);

        // 3 + 5 with exact capture timing
        press(4'h3, 1'b0);
        check("t1_A", A, 4'h3);
        check("t1_state_gota", State, GOT_A);
        @(negedge clk);
        Din = 4'h5; Cin_sw = 1'b0; Load = 1'b1;
        exp_q.push_back(5'h08);
        repeat (LAT) @(negedge clk);
        check("t1_B_not_yet", B, 4'h0);
        @(negedge clk);
        check("t1_B", B, 4'h5);
        check("t1_state_calc", State, CALC);
        check("t1_rv_calc", Result_valid, 1'b0);
        Load = 1'b0;
        @(negedge clk);
        check("t1_state_done", State, DONE);
        check("t1_rv", Result_valid, 1'b1);
        check("t1_result", Result, 5'h08);
        repeat (LAT + 2) @(negedge clk);

        // New operation from DONE keeps old Result visible
        @(negedge clk);
        Din = 4'h2; Load = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("t5_A", A, 4'h2);
        check("t5_rv", Result_valid, 1'b0);
        check("t5_result_held", Result, 5'h08);
        check("t5_state", State, GOT_A);
        Load = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        clear();
        check("clr_outputs", {A, B, Cin, Result, Result_valid}, 32'h0);
        check("clr_state", State, IDLE);

        // F + 1 + 1 and F + F + 1
        exp_q.push_back(5'h11);
        press(4'hF, 1'b1);
        press(4'h1, 1'b1);
        check("t2a_result", Result, 5'h11);
        check("t2a_state", State, DONE);
        Cin_sw = 1'b0; Din = 4'h0;
        repeat (3) @(negedge clk);
        check("t2_cin_hold", Cin, 1'b1);
        check("t2_B_hold", B, 4'h1);
        press(4'hF, 1'b1);
        exp_q.push_back(5'h1F);
        press(4'hF, 1'b1);
        check("t2b_result", Result, 5'h1F);

        // Held Load gives exactly one capture
        clear();
        @(negedge clk);
        Din = 4'h9; Load = 1'b1;
        repeat (50) @(negedge clk);
        check("t3_A", A, 4'h9);
        check("t3_state", State, GOT_A);
        check("t3_B", B, 4'h0);
        Load = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Clr coincident with load pulse in GOT_A drops the load
        @(negedge clk);
        Din = 4'h7; Load = 1'b1;
        repeat (LAT) @(negedge clk);
        Clr = 1'b1;
        @(negedge clk);
        Clr = 1'b0;
        check("t4_clr_state", State, IDLE);
        check("t4_clr_outputs", {A, B, Cin, Result, Result_valid}, 32'h0);
        Load = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("t4_no_late_load", State, IDLE);

        // rst during CALC suppresses the capture
        press(4'h4, 1'b0);
        @(negedge clk);
        Din = 4'h6; Load = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("t4_in_calc", State, CALC);
        rst = 1'b1; Load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_result", Result, 5'h00);
        check("t4_rst_rv", Result_valid, 1'b0);
        check("t4_rst_state", State, IDLE);
        repeat (4) @(negedge clk);

`ifdef LOAD_DEBOUNCE_EN
        // Bouncing Load never captures; the stable level captures once
        clear();
        Din = 4'hA;
        for (int i = 0; i < 10; i++) begin
            Load = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        check("t6_no_bounce_capture", State, IDLE);
        Load = 1'b1;
        repeat (LAT) @(negedge clk);
        check("t6_not_yet", State, IDLE);
        @(negedge clk);
        check("t6_state", State, GOT_A);
        check("t6_A", A, 4'hA);
        repeat (30) @(negedge clk);
        check("t6_single_capture", State, GOT_A);
        Load = 1'b0;
        repeat (LAT + 2) @(negedge clk);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
